// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator and its downstream checker:
// the single feedback rule, the checker FSM states and the common seed.
package lfsr_pkg;

  localparam logic [31:0] SEED = 32'd2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // All-ones mask of the low w bits (w up to 32).
  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Next LFSR value for a w-bit register: shift left, feed back x[2]^x[0].
  function automatic logic [31:0] lfsr_next(input logic [31:0] x, input int unsigned w);
    return {x[30:0], x[2] ^ x[0]} & width_mask(w);
  endfunction

  // Increment a w-bit counter, holding at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = width_mask(w);
    return (v == m) ? m : (v + 32'd1);
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: locks onto the upstream count stream, flags and
// counts mispredictions while locked, and measures the sequence period.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_CNT + 1);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [MS_W-1:0] MS_ONE  = MS_W'(1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(LOSS_CNT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic [MS_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             pv_q, pv_d;

  logic [WIDTH-1:0] pred_w;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic             is_match;
  logic             per_sat;

  // All-zero is the lock-up state, so it never counts as a correct prediction.
  assign pred_w   = WIDTH'(lfsr_next(32'(prev_q), WIDTH));
  assign is_match = (data_in == pred_w) && (data_in != '0);
  assign per_nxt  = CNT_W'(sat_inc(32'(per_q), CNT_W));
  assign err_nxt  = CNT_W'(sat_inc(32'(err_q), CNT_W));
  assign per_sat  = (per_q == '1);

  // State and all counters/outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      prev_q      <= '0;
      ref_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      per_q       <= '0;
      err_q       <= '0;
      period_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      pv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      per_q       <= per_d;
      err_q       <= err_d;
      period_q    <= period_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      pv_q        <= pv_d;
    end
  end

  // FSM next state: clr beats data_vld; no valid sample means no movement.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_SEARCH;
    end else if (data_vld) begin
      case (state_q)
        ST_SEARCH: if (data_in != '0) state_d = ST_VERIFY;
        ST_VERIFY: if (is_match && (match_q == MC_LAST)) state_d = ST_LOCKED;
        ST_LOCKED: if (!is_match && (miss_q == MS_LAST)) state_d = ST_SEARCH;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  // Counter, statistics and pulse next values for the accepted sample.
  always_comb begin
    prev_d      = prev_q;
    ref_d       = ref_q;
    match_d     = match_q;
    miss_d      = miss_q;
    per_d       = per_q;
    err_d       = err_q;
    period_d    = period_q;
    err_pulse_d = 1'b0;
    pv_d        = 1'b0;
    locked_d    = (state_d == ST_LOCKED);
    if (clr) begin
      match_d  = '0;
      miss_d   = '0;
      per_d    = '0;
      err_d    = '0;
      period_d = '0;
    end else if (data_vld) begin
      // Every accepted sample becomes the basis of the next prediction, so an
      // upstream load costs exactly one mismatch.
      prev_d = data_in;
      case (state_q)
        ST_SEARCH: match_d = '0;
        ST_VERIFY: begin
          if (!is_match) begin
            match_d = '0;
          end else if (match_q == MC_LAST) begin
            match_d = '0;
            miss_d  = '0;
            ref_d   = data_in;
            per_d   = '0;
          end else begin
            match_d = match_q + MC_ONE;
          end
        end
        ST_LOCKED: begin
          if (is_match) begin
            miss_d = '0;
            if ((data_in == ref_q) && !per_sat) begin
              period_d = per_nxt;
              pv_d     = 1'b1;
              per_d    = '0;
            end else begin
              per_d = per_nxt;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_d       = err_nxt;
            ref_d       = data_in;
            per_d       = '0;
            miss_d      = (miss_q == MS_LAST) ? '0 : (miss_q + MS_ONE);
          end
        end
        default: ;
      endcase
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_q;
  assign period     = period_q;
  assign period_vld = pv_q;

endmodule
